// File: rtl/tug_referee.sv
// Tug-of-war referee: arbitrates press pulses into rope moves, tracks the winner and scores.
// Optional PRESS_QUEUE_EN macro: remember one press per player made during lockout.
module tug_referee #(
    parameter int N_POS   = 9,
    parameter int LOCKOUT = 4,
    parameter int SCORE_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     press_l,
    input  logic                     press_r,
    output logic [$clog2(N_POS)-1:0] pos,
    output logic                     move_l,
    output logic                     move_r,
    output logic                     win_l,
    output logic                     win_r,
    output logic                     busy,
    output logic [SCORE_W-1:0]       score_l,
    output logic [SCORE_W-1:0]       score_r
);
    localparam int POS_W = $clog2(N_POS);
    localparam int CNT_W = (LOCKOUT > 2) ? $clog2(LOCKOUT) : 1;
    localparam logic [POS_W-1:0]   CENTRE    = POS_W'((N_POS - 1) / 2);
    localparam logic [POS_W-1:0]   L_NEAR    = POS_W'(1);
    localparam logic [POS_W-1:0]   R_NEAR    = POS_W'(N_POS - 2);
    localparam logic [CNT_W-1:0]   CNT_INIT  = CNT_W'((LOCKOUT > 0) ? LOCKOUT - 1 : 0);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {IDLE, PLAY, LOCK, WIN} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] lock_cnt;
    logic             token;      // 0: left wins a tie, 1: right wins a tie
    logic             winner_r;
    logic             eff_l, eff_r;
    logic             grant_l, grant_r;
    logic             hit_l, hit_r;

`ifdef PRESS_QUEUE_EN
    logic pend_l, pend_r;

    // Pending presses only accumulate in LOCK; any PLAY cycle consumes them through arbitration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_l <= 1'b0;
            pend_r <= 1'b0;
        end else if (state == LOCK) begin
            if (press_l) pend_l <= 1'b1;
            if (press_r) pend_r <= 1'b1;
        end else begin
            pend_l <= 1'b0;
            pend_r <= 1'b0;
        end
    end

    assign eff_l = press_l | pend_l;
    assign eff_r = press_r | pend_r;
`else
    assign eff_l = press_l;
    assign eff_r = press_r;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant_l  = 1'b0;
        grant_r  = 1'b0;
        hit_l    = 1'b0;
        hit_r    = 1'b0;
        case (state)
            IDLE: if (start) state_nx = PLAY;
            PLAY: begin
                grant_l = eff_l & (~eff_r | ~token);
                grant_r = eff_r & (~eff_l | token);
                hit_l   = grant_l && (pos == L_NEAR);
                hit_r   = grant_r && (pos == R_NEAR);
                if (hit_l || hit_r)
                    state_nx = WIN;
                else if ((grant_l || grant_r) && LOCKOUT > 0)
                    state_nx = LOCK;
            end
            LOCK: if (lock_cnt == '0) state_nx = PLAY;
            WIN:  if (start) state_nx = PLAY;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == PLAY) || (state == LOCK);
        win_l = (state == WIN) && !winner_r;
        win_r = (state == WIN) &&  winner_r;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos      <= CENTRE;
            move_l   <= 1'b0;
            move_r   <= 1'b0;
            lock_cnt <= '0;
            token    <= 1'b0;
            winner_r <= 1'b0;
            score_l  <= '0;
            score_r  <= '0;
        end else begin
            move_l <= grant_l;
            move_r <= grant_r;

            if ((state == IDLE || state == WIN) && start) pos <= CENTRE;
            else if (grant_l)                             pos <= pos - POS_W'(1);
            else if (grant_r)                             pos <= pos + POS_W'(1);

            if (state == PLAY && eff_l && eff_r) token <= ~token;

            if (state == PLAY && state_nx == LOCK)  lock_cnt <= CNT_INIT;
            else if (state == LOCK && lock_cnt != '0) lock_cnt <= lock_cnt - CNT_W'(1);

            if (hit_l) begin
                winner_r <= 1'b0;
                if (score_l != SCORE_MAX) score_l <= score_l + SCORE_W'(1);
            end
            if (hit_r) begin
                winner_r <= 1'b1;
                if (score_r != SCORE_MAX) score_r <= score_r + SCORE_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_tug_referee.sv
// Bench for tug_referee: vector table plus hand sequences, checked through an expected-value queue.
module tb_tug_referee;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, press_l = 1'b0, press_r = 1'b0;
    logic [3:0] pos;
    logic       move_l, move_r, win_l, win_r, busy;
    logic [2:0] score_l, score_r;

    tug_referee dut (
        .clk(clk), .reset(reset), .start(start), .press_l(press_l), .press_r(press_r),
        .pos(pos), .move_l(move_l), .move_r(move_r), .win_l(win_l), .win_r(win_r),
        .busy(busy), .score_l(score_l), .score_r(score_r)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] pos;
        logic       ml, mr, wl, wr, busy;
        logic [2:0] sl, sr;
    } exp_t;

    typedef struct {
        logic s, pl, pr;
        exp_t e;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

`ifdef PRESS_QUEUE_EN
    localparam bit QUEUED = 1'b1;
`else
    localparam bit QUEUED = 1'b0;
`endif

    function automatic exp_t ex(int p, bit ml, bit mr, bit wl, bit wr, bit b, int sl, int sr);
        exp_t e;
        e.pos = 4'(p); e.ml = ml; e.mr = mr; e.wl = wl; e.wr = wr; e.busy = b;
        e.sl = 3'(sl); e.sr = 3'(sr);
        return e;
    endfunction

    task automatic add(input bit s, input bit pl, input bit pr, input exp_t e);
        vec_t v;
        v.s = s; v.pl = pl; v.pr = pr; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm);
        exp_t e, a;
        e = sb.pop_front();
        a = {pos, move_l, move_r, win_l, win_r, busy, score_l, score_r};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got pos=%0d ml=%b mr=%b wl=%b wr=%b busy=%b sl=%0d sr=%0d exp pos=%0d ml=%b mr=%b wl=%b wr=%b busy=%b sl=%0d sr=%0d",
                     nm, a.pos, a.ml, a.mr, a.wl, a.wr, a.busy, a.sl, a.sr,
                     e.pos, e.ml, e.mr, e.wl, e.wr, e.busy, e.sl, e.sr);
        end
    endtask

    task automatic cyc(input bit s, input bit pl, input bit pr, input exp_t e, input string nm);
        start = s; press_l = pl; press_r = pr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0; press_l = 1'b0; press_r = 1'b0;
        check(nm);
    endtask

    initial begin
        int p;
        // Reset, presses/start ignored in IDLE, then a right-hand win (scores in last two fields).
        add(0,1,0, ex(4,0,0,0,0,0,0,0));
        add(0,0,1, ex(4,0,0,0,0,0,0,0));
        add(1,0,0, ex(4,0,0,0,0,1,0,0));
        add(0,0,1, ex(5,0,1,0,0,1,0,0));
        add(0,0,0, ex(5,0,0,0,0,1,0,0));
        add(1,0,0, ex(5,0,0,0,0,1,0,0));   // start during LOCK is ignored
        add(0,0,0, ex(5,0,0,0,0,1,0,0));
        add(0,0,1, ex(5,0,0,0,0,1,0,0));   // last LOCK cycle: press not granted
        add(0,0,1, ex(6,0,1,0,0,1,0,0));
        add(0,0,0, ex(6,0,0,0,0,1,0,0));
        add(0,0,0, ex(6,0,0,0,0,1,0,0));
        add(0,0,0, ex(6,0,0,0,0,1,0,0));
        add(0,0,1, ex(6,0,0,0,0,1,0,0));
        add(0,0,1, ex(7,0,1,0,0,1,0,0));
        add(0,0,0, ex(7,0,0,0,0,1,0,0));
        add(0,0,0, ex(7,0,0,0,0,1,0,0));
        add(0,0,0, ex(7,0,0,0,0,1,0,0));
        add(0,0,1, ex(7,0,0,0,0,1,0,0));
        add(0,0,1, ex(8,0,1,0,1,0,0,1));   // right end reached: WIN, score_r=1
        add(0,0,1, ex(8,0,0,0,1,0,0,1));
        add(0,1,0, ex(8,0,0,0,1,0,0,1));
        // Token alternation on simultaneous presses.
        add(1,0,0, ex(4,0,0,0,0,1,0,1));
        add(0,1,1, ex(3,1,0,0,0,1,0,1));
        for (int i = 0; i < 4; i++) add(0,0,0, ex(3,0,0,0,0,1,0,1));
        add(0,1,1, ex(4,0,1,0,0,1,0,1));
        for (int i = 0; i < 4; i++) add(0,0,0, ex(4,0,0,0,0,1,0,1));
        // Press during LOCK: dropped, or replayed on the first PLAY cycle when queued.
        add(0,1,0, ex(3,1,0,0,0,1,0,1));
        add(0,0,0, ex(3,0,0,0,0,1,0,1));
        add(0,0,1, ex(3,0,0,0,0,1,0,1));
        add(0,0,0, ex(3,0,0,0,0,1,0,1));
        add(0,0,0, ex(3,0,0,0,0,1,0,1));
        if (QUEUED) add(0,0,0, ex(4,0,1,0,0,1,0,1));
        else        add(0,0,0, ex(3,0,0,0,0,1,0,1));

        #2 reset = 1'b0;
        #1;
        sb.push_back(ex(4,0,0,0,0,0,0,0));
        check("reset_init");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) cyc(tbl[i].s, tbl[i].pl, tbl[i].pr, tbl[i].e, $sformatf("row%0d", i));

        // Walk right to pos 6, then drop reset mid-cycle and check before the next edge.
        p = QUEUED ? 4 : 3;
        for (int i = 0; i < 5; i++) cyc(0,0,0, ex(p,0,0,0,0,1,0,1), "settle");
        while (p < 6) begin
            p++;
            cyc(0,0,1, ex(p,0,1,0,0,1,0,1), "walk");
            if (p < 6) for (int i = 0; i < 4; i++) cyc(0,0,0, ex(p,0,0,0,0,1,0,1), "walk_lock");
        end
        #2 reset = 1'b0;
        #1;
        sb.push_back(ex(4,0,0,0,0,0,0,0));
        check("async_reset");
        @(negedge clk);
        reset = 1'b1;
        cyc(0,1,0, ex(4,0,0,0,0,0,0,0), "idle_after_reset");

        // Eight right wins: score_r saturates at 7.
        for (int k = 1; k <= 8; k++) begin
            int prev;
            prev = (k - 1 > 7) ? 7 : k - 1;
            cyc(1,0,0, ex(4,0,0,0,0,1,0,prev), $sformatf("round%0d_start", k));
            for (int g = 1; g <= 4; g++) begin
                if (g < 4) begin
                    cyc(0,0,1, ex(4+g,0,1,0,0,1,0,prev), $sformatf("round%0d_move%0d", k, g));
                    for (int i = 0; i < 4; i++) cyc(0,0,0, ex(4+g,0,0,0,0,1,0,prev), "round_lock");
                end else begin
                    cyc(0,0,1, ex(8,0,1,0,1,0,0,(k > 7) ? 7 : k), $sformatf("round%0d_win", k));
                end
            end
            cyc(0,1,1, ex(8,0,0,0,1,0,0,(k > 7) ? 7 : k), $sformatf("round%0d_hold", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
